// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// seg_scan : six-digit multiplexed seven-segment driver with frame snapshot
// Rev 1.0  : initial release
// ============================================================================
module seg_scan #(
    parameter int DIV        = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] lit_lsb,
    input  logic [3:0] lit_msb,
    input  logic [3:0] sec_lsb,
    input  logic [3:0] sec_msb,
    input  logic [3:0] min_lsb,
    input  logic [3:0] min_msb,
    input  logic       hold,
    input  logic       blank_lz,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_GUARD   = CNT_W'(2);
    localparam logic [5:0]       C_AN_INV  = {6{ACTIVE_LOW}};
    localparam logic [6:0]       C_SEG_INV = {7{ACTIVE_LOW}};
    localparam logic             C_DP_INV  = ACTIVE_LOW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [5:0][3:0]  snap_q, snap_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             guard;
    logic             blank;
    logic [3:0]       digit;
    logic [6:0]       seg_hi;
    logic [5:0]       an_hi;
    logic             dp_hi;

    always_comb begin
        slot_end = (cnt_q == C_CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        snap_d   = snap_q;
        if (slot_end) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            // Whole-frame capture keeps one frame from mixing two counter values.
            if (idx_q == 3'd5 && !hold) begin
                snap_d = {min_msb, min_lsb, sec_msb, sec_lsb, lit_msb, lit_lsb};
            end
        end
    end

    always_comb begin
        digit = snap_q[idx_q];
        guard = (cnt_q < C_GUARD);
        blank = (idx_q == 3'd5) && blank_lz && (snap_q[5] == 4'd0);

        case (digit)
            4'd0:    seg_hi = 7'b0111111;
            4'd1:    seg_hi = 7'b0000110;
            4'd2:    seg_hi = 7'b1011011;
            4'd3:    seg_hi = 7'b1001111;
            4'd4:    seg_hi = 7'b1100110;
            4'd5:    seg_hi = 7'b1101101;
            4'd6:    seg_hi = 7'b1111101;
            4'd7:    seg_hi = 7'b0000111;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1101111;
            default: seg_hi = 7'b1000000;
        endcase

        an_hi = '0;
        if (!guard && !blank) begin
            an_hi = 6'd1 << idx_q;
        end
        if (blank) begin
            seg_hi = '0;
        end
        dp_hi = !guard && !blank && ((idx_q == 3'd2) || (idx_q == 3'd4));

        an_d  = an_hi ^ C_AN_INV;
        seg_d = seg_hi ^ C_SEG_INV;
        dp_d  = dp_hi ^ C_DP_INV;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= C_AN_INV;
            seg_q  <= C_SEG_INV;
            dp_q   <= C_DP_INV;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// tb_seg_scan : randomized self-checking bench for seg_scan (DIV=4, active-low)
// Rev 1.0     : initial release
// ============================================================================
module tb_seg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    logic            clk = 1'b0;
    logic            clr_n = 1'b1;
    logic [5:0][3:0] dig = '0;
    logic            hold = 1'b0;
    logic            blank_lz = 1'b0;
    wire  [5:0]      an;
    wire  [6:0]      seg;
    wire             dp;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position p counts clock edges since reset release.
    int              p = 0;
    logic [5:0][3:0] m_snap = '0;
    logic [6:0]      lut [16];
    logic [5:0]      exp_an;
    logic [6:0]      exp_seg;
    logic            exp_dp;

    seg_scan #(.DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .lit_lsb  (dig[0]),
        .lit_msb  (dig[1]),
        .sec_lsb  (dig[2]),
        .sec_msb  (dig[3]),
        .min_lsb  (dig[4]),
        .min_msb  (dig[5]),
        .hold     (hold),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int         c, i;
        logic       bl, d_on;
        logic [5:0] a;
        logic [6:0] s;
        c    = p % DIV;
        i    = (p / DIV) % 6;
        bl   = (i == 5) && blank_lz && (m_snap[5] == 4'd0);
        a    = (c < 2 || bl) ? 6'd0 : 6'(1 << i);
        s    = bl ? 7'd0 : lut[m_snap[i]];
        d_on = !bl && (c >= 2) && (i == 2 || i == 4);
        exp_an  = ~a;
        exp_seg = ~s;
        exp_dp  = ~d_on;
        if (c == DIV - 1 && i == 5 && !hold) m_snap = dig;
        p++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic model_reset();
        p      = 0;
        m_snap = '0;
    endtask

    task automatic test_reset();
        #1 clr_n = 1'b0;
        #1;
        n_tests++;
        if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async got an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
        end
        for (int j = 0; j < 10; j++) begin
            dig      = 24'($urandom);
            hold     = 1'($urandom);
            blank_lz = 1'($urandom);
            @(posedge clk);
            #1;
            n_tests++;
            if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got an=%b seg=%b dp=%b want 111111 1111111 1", j, an, seg, dp);
            end
        end
        dig = '0; hold = 1'b0; blank_lz = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        // Zero snapshot shown during the first frame.
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_fail++;
                $display("FAIL first_frame p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_scan();
        dig = {4'd1, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        hold = 1'b0; blank_lz = 1'b0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            n_tests++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_fail++;
                $display("FAIL scan p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (j >= FRAME && (j % FRAME) < 12 && (j % DIV) >= 2) begin
                logic [6:0] want_seg;
                logic       want_dp;
                int         slot;
                slot     = (j % FRAME) / DIV;
                want_seg = (slot == 0) ? ~7'b0000110 : (slot == 1) ? ~7'b1011011 : ~7'b1001111;
                want_dp  = (slot == 2) ? 1'b0 : 1'b1;
                n_tests++;
                if (an !== ~(6'd1 << slot) || seg !== want_seg || dp !== want_dp) begin
                    n_fail++;
                    $display("FAIL scan_slot%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", slot, an, seg, dp, ~(6'd1 << slot), want_seg, want_dp);
                end
            end
        end
    endtask

    task automatic test_blank();
        dig[5] = 4'd0; blank_lz = 1'b1;
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            n_tests++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_fail++;
                $display("FAIL blank p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (j >= FRAME && (j % FRAME) >= 5 * DIV) begin
                n_tests++;
                if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
                    n_fail++;
                    $display("FAIL blank_slot5 got an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
                end
            end
        end
        blank_lz = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            step();
            if ((j % FRAME) >= 5 * DIV + 2) begin
                n_tests++;
                if (an !== 6'b011111 || seg !== ~7'b0111111) begin
                    n_fail++;
                    $display("FAIL noblank_slot5 got an=%b seg=%b want an=011111 seg=%b", an, seg, ~7'b0111111);
                end
            end
        end
    endtask

    task automatic test_hold();
        dig[0] = 4'd3; hold = 1'b0;
        for (int j = 0; j < 2 * FRAME; j++) step();
        hold   = 1'b1;
        dig[0] = 4'd7;
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            n_tests++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_fail++;
                $display("FAIL hold p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if ((j % FRAME) == 2 || (j % FRAME) == 3) begin
                n_tests++;
                if (seg !== ~7'b1001111) begin
                    n_fail++;
                    $display("FAIL hold_keep got seg=%b want %b", seg, ~7'b1001111);
                end
            end
        end
        hold = 1'b0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            if (j >= FRAME && ((j % FRAME) == 2 || (j % FRAME) == 3)) begin
                n_tests++;
                if (an !== 6'b111110 || seg !== ~7'b0000111) begin
                    n_fail++;
                    $display("FAIL hold_release got an=%b seg=%b want an=111110 seg=%b", an, seg, ~7'b0000111);
                end
            end
        end
    endtask

    task automatic test_invalid();
        dig[2] = 4'hC;
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            if (j >= FRAME && ((j % FRAME) == 10 || (j % FRAME) == 11)) begin
                n_tests++;
                if (an !== 6'b111011 || seg !== 7'b0111111 || dp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL invalid_bcd got an=%b seg=%b dp=%b want 111011 0111111 0", an, seg, dp);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            hold     = ($urandom_range(0, 3) == 0);
            blank_lz = 1'($urandom);
            for (int j = 0; j < FRAME; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    for (int k = 0; k < 6; k++) begin
                        dig[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
                    end
                    if ($urandom_range(0, 1) == 0) dig[5] = 4'd0;
                end
                step();
                n_tests++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    n_fail++;
                    $display("FAIL random p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
        hold = 1'b0; blank_lz = 1'b0;
    endtask

    task automatic test_midreset();
        dig = {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        for (int j = 0; j < 2 * FRAME; j++) step();
        while (!(((p / DIV) % 6) == 3 && (p % DIV) == 1)) step();
        #2 clr_n = 1'b0;
        #1;
        n_tests++;
        if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_async got an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
        end
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_fail++;
                $display("FAIL midreset p=%0d got %b_%b_%b want %b_%b_%b", p - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (j < 3) begin
                n_tests++;
                if ((j < 2 && an !== 6'h3F) || (j == 2 && (an !== 6'b111110 || seg !== ~7'b0111111))) begin
                    n_fail++;
                    $display("FAIL midreset_restart edge=%0d got an=%b seg=%b", j + 1, an, seg);
                end
            end
        end
    endtask

    initial begin
        lut[0] = 7'b0111111; lut[1] = 7'b0000110; lut[2] = 7'b1011011; lut[3] = 7'b1001111;
        lut[4] = 7'b1100110; lut[5] = 7'b1101101; lut[6] = 7'b1111101; lut[7] = 7'b0000111;
        lut[8] = 7'b1111111; lut[9] = 7'b1101111;
        for (int k = 10; k < 16; k++) lut[k] = 7'b1000000;

        test_reset();
        test_scan();
        test_blank();
        test_hold();
        test_invalid();
        test_random();
        test_midreset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Six-digit multiplexed seven-segment display driver for the stopwatch. It reads the six BCD digits produced by the time counter (hundredths through tens of minutes) and drives one digit at a time through shared segment lines with one-hot digit enables. It sits between the time counter and the board display pins. Each frame is refreshed from a coherent snapshot, so a display frame never mixes two counter values.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range 4..65535; a frame is 6*DIV cycles.
- ACTIVE_LOW, 1: when 1, `an`, `seg` and `dp` are driven active-low; when 0, active-high.
- clk  in  1  system clock; every register is clocked on its rising edge.
- clr_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- lit_lsb, lit_msb, sec_lsb, sec_msb, min_lsb, min_msb  in  4 each  BCD digits from the time counter.
- hold  in  1  freeze the displayed value (lap/split); sampled only at frame end.
- blank_lz  in  1  blank the tens-of-minutes digit when it is 0.
- an  out  6  digit enables; bit i selects digit i (0 = lit_lsb, 5 = min_msb).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.

## Operation
- Prescaler `cnt`:
  - Counts 0..DIV-1 and wraps to 0.
  - When cnt==DIV-1, the digit index `idx` advances 0→1→…→5→0.
- Snapshot `snap` (6×4 bits):
  - Loads all six inputs on the cycle where cnt==DIV-1, idx==5 and hold==0 (frame end).
  - Otherwise it keeps its value.
  - hold==1 at frame end keeps the old snapshot for a further frame.
- Anti-ghost window:
  - While cnt<2, every `an` bit is inactive.
  - Otherwise only an[idx] is active.
- Digit decode of snap[idx], shown here active-high:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 show a dash, 1000000.
- Blanking: when idx==5, blank_lz==1 and snap[5]==0, seg and dp are all inactive and an[5] stays inactive for the whole slot.
- Decimal point: dp is active when idx==2 (sec.hundredths separator) or idx==4 (min.sec separator), and never during the anti-ghost window.
- Polarity: with ACTIVE_LOW=1, all three outputs are the bitwise inverse of the active-high values.

## Timing
- Reset (clr_n=0, asynchronous):
  - cnt=0, idx=0, snap=all zeros.
  - an, seg and dp take the inactive level (ACTIVE_LOW=1 gives an=111111, seg=1111111, dp=1) immediately, independent of clk.
- Output registers:
  - an, seg and dp are registered.
  - Each output reflects (cnt, idx, snap) as they stood before the same clock edge, i.e. one cycle of latency.
- Slot timing:
  - Each slot is DIV cycles long.
  - It opens with 2 cycles of all-inactive an, followed by DIV-2 cycles with the digit enabled.
  - Slots run continuously; there is no idle gap between frames.
- Snapshot timing:
  - An input change becomes visible, at the earliest, in the frame after the next frame end.
  - After reset, the display shows the zero snapshot (00.00.00, or blank-LZ form) until the first frame end, 6*DIV cycles after reset release.
- Release of clr_n mid-frame restarts the scan at idx=0, cnt=0; no partial frame state survives.
- No input handshake: digits are assumed quasi-static relative to clk, and the snapshot capture is the only sampling point.

## Test plan
- Reset: hold clr_n=0 while toggling all inputs and clk.
  - Required: an=111111, seg=1111111, dp=1 throughout (DIV=4, ACTIVE_LOW=1).
- Scan order: DIV=4, digits lit_lsb..min_msb = 1,2,3,4,5,1, hold=0, blank_lz=0. After the first frame end, each 4-cycle slot i shows:
  - 2 cycles of an=111111;
  - then 2 cycles of an=~(1<<i) with seg as follows:
    - slot 0: ~0000110;
    - slot 1: ~1011011;
    - slot 2: ~1001111, with dp=0 in slot 2 only among the first three;
    - slot 4: dp=0.
- Leading-zero blank: min_msb=0, blank_lz=1.
  - Required: slot 5 has an=111111, seg=1111111, dp=1 for all 4 cycles.
  - With blank_lz=0, slot 5 shows ~0111111.
- Hold: set hold=1 before a frame end, then change lit_lsb from 3 to 7.
  - Required: slot 0 keeps showing 3 (~1001111) for every frame while hold=1.
  - The first frame after a frame end with hold=0 shows 7 (~0000111).
- Invalid BCD: sec_lsb=4'hC.
  - Required: slot 2 shows seg=~1000000 (0111111 on the pins) with dp=0.
- Mid-frame reset: assert clr_n=0 during slot 3 for 1 cycle, then release.
  - Required: outputs go inactive asynchronously.
  - The next enabled digit is digit 0 at cycle 3 after release, showing the zero snapshot (seg=~0111111).
